// File: rtl/color_ctrl_pkg.sv
// color_ctrl_pkg
// Shared definitions for the colour channel controller: channel encoding and
// the RRRGGGBB field layout of the committed colour byte.
// Build option: COLOR_CTRL_DEBOUNCE_EN (consumed by button_debouncer).
package color_ctrl_pkg;

    // Channel encoding; CH_RSVD is unreachable and recovers to CH_RED.
    typedef enum logic [1:0] {
        CH_RED   = 2'b00,
        CH_GREEN = 2'b01,
        CH_BLUE  = 2'b10,
        CH_RSVD  = 2'b11
    } channel_e;

    localparam int unsigned RGB_W = 8;

    localparam int unsigned R_MSB = 7;
    localparam int unsigned R_LSB = 5;
    localparam int unsigned R_W   = 3;

    localparam int unsigned G_MSB = 4;
    localparam int unsigned G_LSB = 2;
    localparam int unsigned G_W   = 3;

    localparam int unsigned B_MSB = 1;
    localparam int unsigned B_LSB = 0;
    localparam int unsigned B_W   = 2;

    // Next channel on an accepted button press.
    function automatic channel_e next_channel(input channel_e ch);
        case (ch)
            CH_RED:   return CH_GREEN;
            CH_GREEN: return CH_BLUE;
            default:  return CH_RED;
        endcase
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
// Two-flop synchronizer followed by an optional counter debouncer.
// Ports:
//   clk_i    - clock, all state on rising edge
//   rst_ni   - synchronous active-low reset
//   button_i - raw asynchronous push-button
//   level_o  - accepted (synchronized, optionally debounced) button level
// Build option: COLOR_CTRL_DEBOUNCE_EN defined compiles in the debouncer;
// undefined, level_o is the synchronizer output and DEBOUNCE_CYCLES is ignored.
module button_debouncer
    import color_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic button_i,
    output logic level_o
);

    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], button_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef COLOR_CTRL_DEBOUNCE_EN
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;

    // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
`else
    logic unused_debounce_cycles;
    assign unused_debounce_cycles = ^DEBOUNCE_CYCLES;

    assign level_o = sync_q[1];
`endif

endmodule

// File: rtl/color_channel_ctrl.sv
// color_channel_ctrl
// Button-selected colour channel editor. The selected channel's field of a
// staging byte follows SWITCHES every cycle; the staging byte is committed to
// RGB_OUT on FRAME_START. A debounced button press steps RED->GREEN->BLUE.
// Ports:
//   CLK_IN      - clock, all state on rising edge
//   RST_N       - synchronous active-low reset
//   SWITCHES    - colour value for the selected channel (blue uses [1:0])
//   BUTTON      - raw push-button, advances the channel
//   FRAME_START - commit strobe (start of vertical blanking)
//   RGB_OUT     - committed colour, RRRGGGBB
//   CHANNEL     - current channel: 00 red, 01 green, 10 blue
//   PENDING     - staging differs from RGB_OUT
// Build option: COLOR_CTRL_DEBOUNCE_EN enables the button debouncer.
module color_channel_ctrl
    import color_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLK_IN,
    input  logic             RST_N,
    input  logic [2:0]       SWITCHES,
    input  logic             BUTTON,
    input  logic             FRAME_START,
    output logic [RGB_W-1:0] RGB_OUT,
    output logic [1:0]       CHANNEL,
    output logic             PENDING
);

    logic             level;
    logic             level_prev_q, level_prev_d;
    logic             press;
    channel_e         ch_q, ch_d;
    logic [RGB_W-1:0] stage_q, stage_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_debouncer (
        .clk_i   (CLK_IN),
        .rst_ni  (RST_N),
        .button_i(BUTTON),
        .level_o (level)
    );

    always_comb begin
        level_prev_d = level;
        press        = level & ~level_prev_q;

        ch_d = ch_q;
        if (ch_q == CH_RSVD) begin
            ch_d = CH_RED;
        end else if (press) begin
            ch_d = next_channel(ch_q);
        end

        // Staging follows the channel held before this edge's advance.
        stage_d = stage_q;
        case (ch_q)
            CH_RED:   stage_d[R_MSB:R_LSB] = SWITCHES[R_W-1:0];
            CH_GREEN: stage_d[G_MSB:G_LSB] = SWITCHES[G_W-1:0];
            CH_BLUE:  stage_d[B_MSB:B_LSB] = SWITCHES[B_W-1:0];
            default:  stage_d = stage_q;
        endcase

        rgb_d = FRAME_START ? stage_q : rgb_q;
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            level_prev_q <= 1'b0;
            ch_q         <= CH_RED;
            stage_q      <= '0;
            rgb_q        <= '0;
        end else begin
            level_prev_q <= level_prev_d;
            ch_q         <= ch_d;
            stage_q      <= stage_d;
            rgb_q        <= rgb_d;
        end
    end

    assign RGB_OUT = rgb_q;
    assign CHANNEL = ch_q;
    assign PENDING = (stage_q != rgb_q);

endmodule

// File: tb/tb_color_channel_ctrl.sv
// tb_color_channel_ctrl
// Directed scenarios plus randomized traffic against a behavioural model.
// Honours COLOR_CTRL_DEBOUNCE_EN for the expected press latency.
module tb_color_channel_ctrl;

    localparam int unsigned N = 4;
`ifdef COLOR_CTRL_DEBOUNCE_EN
    localparam int L = N + 3;
`else
    localparam int L = 3;
`endif

    logic       CLK_IN = 1'b0;
    logic       RST_N;
    logic [2:0] SWITCHES;
    logic       BUTTON;
    logic       FRAME_START;
    logic [7:0] RGB_OUT;
    logic [1:0] CHANNEL;
    logic       PENDING;

    int errors = 0;
    int checks = 0;

    always #5 CLK_IN = ~CLK_IN;

    color_channel_ctrl #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .CLK_IN     (CLK_IN),
        .RST_N      (RST_N),
        .SWITCHES   (SWITCHES),
        .BUTTON     (BUTTON),
        .FRAME_START(FRAME_START),
        .RGB_OUT    (RGB_OUT),
        .CHANNEL    (CHANNEL),
        .PENDING    (PENDING)
    );

    // Behavioural model: channel is the count of accepted presses mod 3,
    // colour fields are kept separately and packed only on commit.
    logic       m_sync1, m_sync2, m_acc, m_prev;
    int         m_cnt;
    int         m_presses;
    logic [2:0] m_r, m_g;
    logic [1:0] m_b;
    logic [7:0] m_rgb;
    logic       m_acc_now;
    logic [1:0] m_ch;
    logic       m_pending;

`ifdef COLOR_CTRL_DEBOUNCE_EN
    assign m_acc_now = m_acc;
`else
    assign m_acc_now = m_sync2;
`endif
    assign m_ch      = 2'(m_presses % 3);
    assign m_pending = ({m_r, m_g, m_b} != m_rgb);

    always @(posedge CLK_IN) begin
        if (!RST_N) begin
            m_sync1   <= 1'b0;
            m_sync2   <= 1'b0;
            m_acc     <= 1'b0;
            m_prev    <= 1'b0;
            m_cnt     <= 0;
            m_presses <= 0;
            m_r       <= '0;
            m_g       <= '0;
            m_b       <= '0;
            m_rgb     <= '0;
        end else begin
            m_sync1 <= BUTTON;
            m_sync2 <= m_sync1;
            m_prev  <= m_acc_now;
            if (m_acc_now && !m_prev) m_presses <= m_presses + 1;
            if (m_ch == 2'd0) m_r <= SWITCHES;
            if (m_ch == 2'd1) m_g <= SWITCHES;
            if (m_ch == 2'd2) m_b <= SWITCHES[1:0];
            if (FRAME_START) m_rgb <= {m_r, m_g, m_b};
            if (m_sync2 != m_acc) begin
                if (m_cnt == int'(N) - 1) begin
                    m_acc <= m_sync2;
                    m_cnt <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                m_cnt <= 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK_IN);
            @(negedge CLK_IN);
        end
    endtask

    task automatic do_reset();
        RST_N       = 1'b0;
        BUTTON      = 1'b0;
        FRAME_START = 1'b0;
        tick(3);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N       = 1'b0;
        SWITCHES    = 3'b111;
        BUTTON      = 1'b1;
        FRAME_START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks += 3;
            if (RGB_OUT !== 8'h00) begin
                errors++;
                $display("FAIL reset_rgb: got %h expected 00", RGB_OUT);
            end
            if (CHANNEL !== 2'b00) begin
                errors++;
                $display("FAIL reset_channel: got %b expected 00", CHANNEL);
            end
            if (PENDING !== 1'b0) begin
                errors++;
                $display("FAIL reset_pending: got %b expected 0", PENDING);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [1:0] exp;
        do_reset();
        SWITCHES = 3'b000;
        BUTTON   = 1'b1;
        for (int e = 1; e <= L + N + 4; e++) begin
            tick(1);
            exp = (e >= L) ? 2'b01 : 2'b00;
            checks++;
            if (CHANNEL !== exp) begin
                errors++;
                $display("FAIL press_latency edge %0d: got %b expected %b", e, CHANNEL, exp);
            end
        end
        BUTTON = 1'b0;
        tick(L + 3);
        BUTTON = 1'b1;
        tick(L + 3);
        BUTTON = 1'b0;
        tick(L + 3);
        checks++;
        if (CHANNEL !== 2'b10) begin
            errors++;
            $display("FAIL second_press: got %b expected 10", CHANNEL);
        end
        BUTTON = 1'b1;
        tick(L + 3);
        BUTTON = 1'b0;
        tick(L + 3);
        checks++;
        if (CHANNEL !== 2'b00) begin
            errors++;
            $display("FAIL third_press_wrap: got %b expected 00", CHANNEL);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            BUTTON = ((i / 2) % 2 == 0);
            tick(1);
        end
        BUTTON = 1'b0;
        tick(N + 4);
`ifdef COLOR_CTRL_DEBOUNCE_EN
        checks++;
        if (CHANNEL !== 2'b00) begin
            errors++;
            $display("FAIL bounce_ignored: got %b expected 00", CHANNEL);
        end
`endif
        checks++;
        if (CHANNEL !== m_ch) begin
            errors++;
            $display("FAIL bounce_model: got %b expected %b", CHANNEL, m_ch);
        end
    endtask

    task automatic test_commit();
        do_reset();
        SWITCHES = 3'b101;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks += 2;
            if (PENDING !== 1'b1) begin
                errors++;
                $display("FAIL commit_pending_before: got %b expected 1", PENDING);
            end
            if (RGB_OUT !== 8'h00) begin
                errors++;
                $display("FAIL commit_rgb_before: got %h expected 00", RGB_OUT);
            end
        end
        FRAME_START = 1'b1;
        tick(1);
        FRAME_START = 1'b0;
        checks += 2;
        if (RGB_OUT !== 8'hA0) begin
            errors++;
            $display("FAIL commit_rgb: got %h expected a0", RGB_OUT);
        end
        if (PENDING !== 1'b0) begin
            errors++;
            $display("FAIL commit_pending_after: got %b expected 0", PENDING);
        end
    endtask

    // Step to blue with SWITCHES=101, then commit on the same edge as the wrap.
    task automatic test_blue_simul();
        for (int p = 0; p < 2; p++) begin
            BUTTON = 1'b1;
            tick(L + 2);
            BUTTON = 1'b0;
            tick(L + 3);
        end
        SWITCHES = 3'b111;
        tick(2);
        BUTTON = 1'b1;
        tick(L - 1);
        FRAME_START = 1'b1;
        tick(1);
        FRAME_START = 1'b0;
        checks += 4;
        if (CHANNEL !== 2'b00) begin
            errors++;
            $display("FAIL simul_channel: got %b expected 00", CHANNEL);
        end
        if (RGB_OUT[1:0] !== 2'b11) begin
            errors++;
            $display("FAIL simul_blue: got %b expected 11", RGB_OUT[1:0]);
        end
        if (RGB_OUT[7:2] !== 6'b101101) begin
            errors++;
            $display("FAIL simul_upper: got %b expected 101101", RGB_OUT[7:2]);
        end
        if (RGB_OUT !== m_rgb) begin
            errors++;
            $display("FAIL simul_model: got %h expected %h", RGB_OUT, m_rgb);
        end
        BUTTON = 1'b0;
        tick(L + 3);
    endtask

    task automatic test_back_to_back();
        FRAME_START = 1'b1;
        for (int i = 0; i < 6; i++) begin
            SWITCHES = 3'($urandom);
            tick(1);
            checks += 2;
            if (RGB_OUT !== m_rgb) begin
                errors++;
                $display("FAIL b2b_rgb %0d: got %h expected %h", i, RGB_OUT, m_rgb);
            end
            if (PENDING !== m_pending) begin
                errors++;
                $display("FAIL b2b_pending %0d: got %b expected %b", i, PENDING, m_pending);
            end
        end
        FRAME_START = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        SWITCHES = 3'b110;
        BUTTON   = 1'b1;
        tick(L - 1);
        RST_N       = 1'b0;
        FRAME_START = 1'b1;
        tick(1);
        checks += 3;
        if (CHANNEL !== 2'b00) begin
            errors++;
            $display("FAIL midreset_channel: got %b expected 00", CHANNEL);
        end
        if (RGB_OUT !== 8'h00) begin
            errors++;
            $display("FAIL midreset_rgb: got %h expected 00", RGB_OUT);
        end
        if (PENDING !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pending: got %b expected 0", PENDING);
        end
        RST_N       = 1'b1;
        FRAME_START = 1'b0;
        BUTTON      = 1'b0;
        tick(1);
        checks++;
        if (PENDING !== 1'b1) begin
            errors++;
            $display("FAIL postreset_first_load: got %b expected 1", PENDING);
        end
        tick(L + 3);
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                BUTTON = ~BUTTON;
                hold   = $urandom_range(1, 2 * N + 4);
            end
            hold--;
            SWITCHES    = 3'($urandom);
            FRAME_START = ($urandom_range(0, 7) == 0);
            RST_N       = ($urandom_range(0, 299) != 0);
            tick(1);
            checks += 3;
            if (CHANNEL !== m_ch) begin
                errors++;
                $display("FAIL rand_channel %0d: got %b expected %b", i, CHANNEL, m_ch);
            end
            if (RGB_OUT !== m_rgb) begin
                errors++;
                $display("FAIL rand_rgb %0d: got %h expected %h", i, RGB_OUT, m_rgb);
            end
            if (PENDING !== m_pending) begin
                errors++;
                $display("FAIL rand_pending %0d: got %b expected %b", i, PENDING, m_pending);
            end
        end
        RST_N       = 1'b1;
        FRAME_START = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_commit();
        test_blue_simul();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/color_channel_ctrl.md
COLOR_CHANNEL_CTRL -- requirements
Module: color_channel_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000, the number of consecutive disagreeing cycles needed to accept a new button level (10 ms at 50 MHz).
REQ-002 Port: CLK_IN  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: RST_N  input  1  reset, synchronous, active-low.
REQ-004 Port: SWITCHES  input  3  user colour value for the selected channel.
REQ-005 Port: BUTTON  input  1  raw, asynchronous, bouncing push-button.
REQ-006 Port: FRAME_START  input  1  one-cycle pulse from the sync generator marking the start of vertical blanking.
REQ-007 Port: RGB_OUT  output  8  committed colour in RRRGGGBB format; bits [7:5] red, [4:2] green, [1:0] blue.
REQ-008 Port: CHANNEL  output  2  current channel: 00 red, 01 green, 10 blue.
REQ-009 Port: PENDING  output  1  high while the staged colour differs from RGB_OUT.

Function
REQ-010 BUTTON SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Debouncer: a counter SHALL increment each cycle that the synchronized level differs from the accepted level, and clear to 0 on any cycle they agree.
REQ-012 When the counter reaches DEBOUNCE_CYCLES-1 while still disagreeing, the accepted level SHALL take the synchronized value and the counter SHALL clear.
REQ-013 A rising edge of the accepted level SHALL advance CHANNEL exactly once.
REQ-014 Channel FSM transitions: RED->GREEN->BLUE->RED; encoding 11 is unreachable and SHALL go to RED on the next cycle.
REQ-015 Latency: if BUTTON is held high, CHANNEL SHALL update on rising edge DEBOUNCE_CYCLES+3, counting the first edge that samples BUTTON high as edge 1.
REQ-016 Falling edges and bounces shorter than DEBOUNCE_CYCLES SHALL NOT change CHANNEL.
REQ-017 Staging register: each cycle, the field of the current channel SHALL load from SWITCHES (blue loads SWITCHES[1:0]), and the other fields SHALL hold.
REQ-018 The staging update SHALL use the CHANNEL value from before any same-cycle channel advance.
REQ-019 RGB_OUT SHALL change only on a cycle where FRAME_START=1, loading the staging value as registered before that edge.
REQ-020 PENDING SHALL be combinational: (staging != RGB_OUT).
REQ-021 When a channel advance and FRAME_START occur in the same cycle, both SHALL take effect independently.
REQ-022 FRAME_START pulses on consecutive cycles SHALL each commit; no pulse is lost.

Reset
REQ-023 While RST_N=0 at a clock edge: RGB_OUT=8'h00, staging=8'h00, CHANNEL=00, accepted level=0, debounce counter=0, synchronizer flops=0.
REQ-024 Reset asserted mid-debounce or mid-frame SHALL abandon the operation in progress; no commit or channel advance occurs on that edge.
REQ-025 After release, the first staging load SHALL occur on the first edge with RST_N=1.

Configuration
REQ-026 Macro COLOR_CTRL_DEBOUNCE_EN defined: the debouncer of REQ-011/012 is compiled in.
REQ-027 Macro COLOR_CTRL_DEBOUNCE_EN undefined: the accepted level SHALL equal the synchronizer output and DEBOUNCE_CYCLES is ignored; CHANNEL then updates on edge 3 per REQ-015 counting.

Structure
REQ-028 Shared package color_ctrl_pkg SHALL hold the channel encoding constants (CH_RED, CH_GREEN, CH_BLUE) and the RGB field offsets and widths (R 7:5, G 4:2, B 1:0).
REQ-029 Synchronizer plus debouncer SHALL be one sub-module, button_debouncer, that outputs the accepted level; edge detection stays in color_channel_ctrl.

Verification (DEBOUNCE_CYCLES=4 unless noted)
REQ-030 Reset: hold RST_N=0 for 3 cycles with SWITCHES=3'b111, BUTTON=1 -> RGB_OUT=00, CHANNEL=00, PENDING=0 throughout.
REQ-031 Clean press: BUTTON high from edge 1 -> CHANNEL=01 at edge 7, stays 01 while held; three presses return CHANNEL to 00.
REQ-032 Bounce: BUTTON toggles every 2 cycles for 20 cycles, then low -> CHANNEL unchanged.
REQ-033 Commit: CHANNEL=00, SWITCHES=3'b101 -> PENDING=1 and RGB_OUT=00 until the FRAME_START pulse; RGB_OUT=8'hA0 on the edge after it, then PENDING=0.
REQ-034 Blue field and simultaneity: CHANNEL=10, SWITCHES=3'b111, with the advance and FRAME_START on the same edge -> RGB_OUT[1:0]=11, RGB_OUT[7:2] unchanged, CHANNEL=00.
REQ-035 Macro undefined: BUTTON high from edge 1 -> CHANNEL advances at edge 3; mid-count reset with the macro defined -> no advance.
